// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle main control FSM for the MIPS-subset datapath
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [1:0] pc_src,
  output logic [3:0] ALUctr,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct to ALU operation; unlisted functs map to addu
  function automatic logic [3:0] r_aluctr(input logic [5:0] f);
    case (f)
      6'b100001: r_aluctr = 4'b0000;
      6'b100000: r_aluctr = 4'b0001;
      6'b100100: r_aluctr = 4'b0010;
      6'b100101: r_aluctr = 4'b0011;
      6'b100011: r_aluctr = 4'b0100;
      6'b100010: r_aluctr = 4'b0101;
      6'b101011: r_aluctr = 4'b0110;
      6'b101010: r_aluctr = 4'b0111;
      default:   r_aluctr = 4'b0000;
    endcase
  endfunction

  function automatic logic r_legal(input logic [5:0] f);
    case (f)
      6'b100001, 6'b100000, 6'b100100, 6'b100101,
      6'b100011, 6'b100010, 6'b101011, 6'b101010: r_legal = 1'b1;
      default:                                    r_legal = 1'b0;
    endcase
  endfunction

  state_t cur, nxt, tgt;
  logic   dec_illegal;
  logic   valid;

  // Registered Moore outputs belonging to the current state
  logic       ir_write_q, pc_write_q, mem_read_q, mem_write_q, reg_write_q;
  logic       iord_q, mem_to_reg_q, reg_dst_q, alu_src_a_q, ext_op_q;
  logic       done_q, branch_q;
  logic [1:0] alu_src_b_q, pc_src_q;
  logic [3:0] aluctr_q;

  // Output set for the state being entered at the next edge
  logic       ir_write_d, pc_write_d, mem_read_d, mem_write_d, reg_write_d;
  logic       iord_d, mem_to_reg_d, reg_dst_d, alu_src_a_d, ext_op_d;
  logic       done_d, branch_d;
  logic [1:0] alu_src_b_d, pc_src_d;
  logic [3:0] aluctr_d;

  // Opcode check in DECODE; op is valid only once IR has been loaded
  always_comb begin
    dec_illegal = 1'b0;
    if (cur == S_DECODE) begin
      case (op)
        OP_RTYPE: dec_illegal = !r_legal(funct);
        OP_LW, OP_SW, OP_ORI, OP_ADDIU, OP_LUI, OP_BEQ, OP_J: dec_illegal = 1'b0;
        default:  dec_illegal = 1'b1;
      endcase
    end
  end

  // Next-state logic; reset always targets FETCH
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:                nxt = r_legal(funct) ? S_EXEC_R : S_FETCH;
          OP_LW, OP_SW:            nxt = S_MEM_ADDR;
          OP_ORI, OP_ADDIU, OP_LUI: nxt = S_EXEC_I;
          OP_BEQ:                  nxt = S_BRANCH;
          OP_J:                    nxt = S_JUMP;
          default:                 nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR: nxt = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   nxt = S_MEM_WB;
      S_EXEC_R:   nxt = S_WB_R;
      S_EXEC_I:   nxt = S_WB_I;
      default:    nxt = S_FETCH;
    endcase
    tgt = rst_n ? nxt : S_FETCH;
  end

  // Control word for the target state, so outputs come straight from flops
  always_comb begin
    ir_write_d   = 1'b0;
    pc_write_d   = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    iord_d       = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_dst_d    = 1'b0;
    alu_src_a_d  = 1'b0;
    ext_op_d     = 1'b0;
    done_d       = 1'b0;
    branch_d     = 1'b0;
    alu_src_b_d  = 2'b00;
    pc_src_d     = 2'b00;
    aluctr_d     = 4'b0000;
    case (tgt)
      S_FETCH: begin
        mem_read_d  = 1'b1;
        ir_write_d  = 1'b1;
        alu_src_b_d = 2'b01;
        pc_write_d  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b_d = 2'b11;
        ext_op_d    = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        ext_op_d    = 1'b1;
      end
      S_MEM_RD: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
        done_d       = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
        done_d      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_d = 1'b1;
        aluctr_d    = r_aluctr(funct);
      end
      S_WB_R: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
        done_d      = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        case (op)
          OP_ORI:   aluctr_d = 4'b0011;
          OP_LUI:   aluctr_d = 4'b1000;
          default: begin
            aluctr_d = 4'b0000;
            ext_op_d = 1'b1;
          end
        endcase
      end
      S_WB_I: begin
        reg_write_d = 1'b1;
        done_d      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d = 1'b1;
        aluctr_d    = 4'b0100;
        pc_src_d    = 2'b01;
        done_d      = 1'b1;
        branch_d    = 1'b1;
      end
      S_JUMP: begin
        pc_write_d = 1'b1;
        pc_src_d   = 2'b10;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // State register and registered control word
  always_ff @(posedge clk) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
    ir_write_q   <= ir_write_d;
    pc_write_q   <= pc_write_d;
    mem_read_q   <= mem_read_d;
    mem_write_q  <= mem_write_d;
    reg_write_q  <= reg_write_d;
    iord_q       <= iord_d;
    mem_to_reg_q <= mem_to_reg_d;
    reg_dst_q    <= reg_dst_d;
    alu_src_a_q  <= alu_src_a_d;
    ext_op_q     <= ext_op_d;
    done_q       <= done_d;
    branch_q     <= branch_d;
    alu_src_b_q  <= alu_src_b_d;
    pc_src_q     <= pc_src_d;
    aluctr_q     <= aluctr_d;
  end

  // Reset and unused state codes force every output inactive
  always_comb begin
    valid      = rst_n && (cur <= S_JUMP);
    ir_write   = valid & ir_write_q;
    pc_write   = valid & (pc_write_q | (branch_q & zero));
    mem_read   = valid & mem_read_q;
    mem_write  = valid & mem_write_q;
    reg_write  = valid & reg_write_q;
    iord       = valid & iord_q;
    mem_to_reg = valid & mem_to_reg_q;
    reg_dst    = valid & reg_dst_q;
    alu_src_a  = valid & alu_src_a_q;
    alu_src_b  = valid ? alu_src_b_q : 2'b00;
    ext_op     = valid & ext_op_q;
    pc_src     = valid ? pc_src_q : 2'b00;
    ALUctr     = valid ? aluctr_q : 4'b0000;
    instr_done = valid & (done_q | dec_illegal);
    illegal    = valid & dec_illegal;
    state      = rst_n ? cur : 4'd0;
  end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed bench for mc_control
`timescale 1ns/1ps
module tb_mc_control;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero;
  logic       ir_write, pc_write, mem_read, mem_write, reg_write, iord;
  logic       mem_to_reg, reg_dst, alu_src_a, ext_op, instr_done, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] ALUctr, state;
  logic [19:0] ctl;

  int total = 0;
  int bad   = 0;

  localparam logic [19:0] IRW  = 20'h1 << 19;
  localparam logic [19:0] PCW  = 20'h1 << 18;
  localparam logic [19:0] MRD  = 20'h1 << 17;
  localparam logic [19:0] MWR  = 20'h1 << 16;
  localparam logic [19:0] RGW  = 20'h1 << 15;
  localparam logic [19:0] IORD = 20'h1 << 14;
  localparam logic [19:0] M2R  = 20'h1 << 13;
  localparam logic [19:0] RDST = 20'h1 << 12;
  localparam logic [19:0] SRCA = 20'h1 << 11;
  localparam logic [19:0] EXT  = 20'h1 << 8;
  localparam logic [19:0] DONE = 20'h1 << 1;
  localparam logic [19:0] ILL  = 20'h1;

  function automatic logic [19:0] sb(input int v);  sb  = 20'(v) << 9; endfunction
  function automatic logic [19:0] pcs(input int v); pcs = 20'(v) << 6; endfunction
  function automatic logic [19:0] alu(input int v); alu = 20'(v) << 2; endfunction

  logic [19:0] fetch_e, decode_e;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .iord(iord),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .pc_src(pc_src), .ALUctr(ALUctr),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  assign ctl = {ir_write, pc_write, mem_read, mem_write, reg_write, iord,
                mem_to_reg, reg_dst, alu_src_a, alu_src_b, ext_op, pc_src,
                ALUctr, instr_done, illegal};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input int st, input logic [19:0] e);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_ctl"}, 32'(ctl), 32'(e));
  endtask

  initial begin
    fetch_e  = IRW | PCW | MRD | sb(1);
    decode_e = sb(3) | EXT;
    rst_n = 1'b0; op = 6'b000000; funct = 6'b100001; zero = 1'b1;
    repeat (3) tick();
    expect_cyc("reset", 0, 20'h0);

    // addu
    @(negedge clk); rst_n = 1'b1; #1;
    expect_cyc("addu_f", 0, fetch_e);
    tick(); expect_cyc("addu_d", 1, decode_e);
    tick(); expect_cyc("addu_x", 6, SRCA | alu(0));
    tick(); expect_cyc("addu_w", 7, RGW | RDST | DONE);
    tick(); expect_cyc("lw_f", 0, fetch_e);

    // lw then sw
    op = 6'b100011;
    tick(); expect_cyc("lw_d", 1, decode_e);
    tick(); expect_cyc("lw_a", 2, SRCA | sb(2) | EXT);
    tick(); expect_cyc("lw_r", 3, MRD | IORD);
    tick(); expect_cyc("lw_w", 4, RGW | M2R | DONE);
    tick(); expect_cyc("sw_f", 0, fetch_e);
    op = 6'b101011;
    tick(); expect_cyc("sw_d", 1, decode_e);
    tick(); expect_cyc("sw_a", 2, SRCA | sb(2) | EXT);
    tick(); expect_cyc("sw_w", 5, MWR | IORD | DONE);
    tick(); expect_cyc("beq1_f", 0, fetch_e);

    // beq taken, then not taken
    op = 6'b000100;
    tick(); expect_cyc("beq1_d", 1, decode_e);
    tick(); expect_cyc("beq1_b", 10, PCW | SRCA | alu(4) | pcs(1) | DONE);
    tick(); expect_cyc("beq2_f", 0, fetch_e);
    tick(); expect_cyc("beq2_d", 1, decode_e);
    zero = 1'b0;
    tick(); expect_cyc("beq2_b", 10, SRCA | alu(4) | pcs(1) | DONE);
    zero = 1'b1;
    tick(); expect_cyc("ori_f", 0, fetch_e);

    // I-type ALU ops
    op = 6'b001101;
    tick(); expect_cyc("ori_d", 1, decode_e);
    tick(); expect_cyc("ori_x", 8, SRCA | sb(2) | alu(3));
    tick(); expect_cyc("ori_w", 9, RGW | DONE);
    tick(); expect_cyc("lui_f", 0, fetch_e);
    op = 6'b001111;
    tick(); expect_cyc("lui_d", 1, decode_e);
    tick(); expect_cyc("lui_x", 8, SRCA | sb(2) | alu(8));
    tick(); expect_cyc("lui_w", 9, RGW | DONE);
    tick(); expect_cyc("addiu_f", 0, fetch_e);
    op = 6'b001001;
    tick(); expect_cyc("addiu_d", 1, decode_e);
    tick(); expect_cyc("addiu_x", 8, SRCA | sb(2) | EXT | alu(0));
    tick(); expect_cyc("addiu_w", 9, RGW | DONE);
    tick(); expect_cyc("j_f", 0, fetch_e);

    // jump
    op = 6'b000010;
    tick(); expect_cyc("j_d", 1, decode_e);
    tick(); expect_cyc("j_j", 11, PCW | pcs(2) | DONE);
    tick(); expect_cyc("ill1_f", 0, fetch_e);

    // illegal opcode and illegal funct
    op = 6'b111111;
    tick(); expect_cyc("ill1_d", 1, decode_e | DONE | ILL);
    tick(); expect_cyc("ill2_f", 0, fetch_e);
    op = 6'b000000; funct = 6'b000111;
    tick(); expect_cyc("ill2_d", 1, decode_e | DONE | ILL);
    tick(); expect_cyc("sub_f", 0, fetch_e);

    // more R-type functs
    funct = 6'b100010;
    tick(); expect_cyc("sub_d", 1, decode_e);
    tick(); expect_cyc("sub_x", 6, SRCA | alu(5));
    tick(); expect_cyc("sub_w", 7, RGW | RDST | DONE);
    tick(); expect_cyc("slt_f", 0, fetch_e);
    funct = 6'b101010;
    tick(); expect_cyc("slt_d", 1, decode_e);
    tick(); expect_cyc("slt_x", 6, SRCA | alu(7));
    tick(); expect_cyc("slt_w", 7, RGW | RDST | DONE);
    tick(); expect_cyc("lw2_f", 0, fetch_e);

    // reset during MEM_RD
    op = 6'b100011;
    tick(); expect_cyc("lw2_d", 1, decode_e);
    tick(); expect_cyc("lw2_a", 2, SRCA | sb(2) | EXT);
    tick(); expect_cyc("lw2_r", 3, MRD | IORD);
    rst_n = 1'b0; #1;
    expect_cyc("rst_mid", 0, 20'h0);
    tick(); expect_cyc("rst_hold", 0, 20'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    expect_cyc("rel_f", 0, fetch_e);
    tick(); expect_cyc("rel_d", 1, decode_e);
    tick(); expect_cyc("rel_a", 2, SRCA | sb(2) | EXT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit for the CPU datapath: a Moore-style FSM that sequences fetch, decode, execute, memory and write-back for the supported MIPS subset. It drives the memory, register-file, PC and mux selects, and is the sole producer of the 4-bit `ALUctr` code consumed by the datapath ALU. It takes `op`/`funct` from the instruction register and `zero` from the ALU.

## Interface
No parameters.
- `clk` input 1: clock; all state changes on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `op` input 6: IR[31:26], stable from the end of FETCH until the next FETCH.
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU zero flag, used only in BRANCH.
- `ir_write`, `pc_write`, `mem_read`, `mem_write`, `reg_write` output 1: enables.
- `iord` output 1: 0 = memory address from PC, 1 = from ALUOut.
- `mem_to_reg` output 1: 1 = write-back from MDR, 0 = from ALUOut.
- `reg_dst` output 1: 1 = rd, 0 = rt.
- `alu_src_a` output 1: 0 = PC, 1 = reg A.
- `alu_src_b` output 2: 00 = reg B, 01 = constant 4, 10 = extended imm, 11 = extended imm<<2.
- `ext_op` output 1: 1 = sign-extend, 0 = zero-extend.
- `pc_src` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUctr` output 4: 0000 addu, 0001 add, 0010 and, 0011 or, 0100 subu, 0101 sub, 0110 sltu, 0111 slt, 1000 lui.
- `instr_done` output 1: high in the last cycle of every instruction.
- `illegal` output 1: one-cycle pulse in DECODE on an unsupported opcode or funct.
- `state` output 4: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, WB_R=7, EXEC_I=8, WB_I=9, BRANCH=10, JUMP=11. Codes 12-15 go to FETCH with all outputs inactive.
- Unlisted outputs are 0 in every state. `ALUctr` defaults to 0000.
- FETCH: `mem_read`=1, `iord`=0, `ir_write`=1, `alu_src_b`=01, `pc_write`=1, `pc_src`=00. Next state is DECODE.
- DECODE: `alu_src_b`=11, `ext_op`=1, so the branch target lands in ALUOut. Next state by opcode:
  - op 000000 (R-type) → EXEC_R.
  - 100011 lw / 101011 sw → MEM_ADDR.
  - 001101 ori, 001001 addiu, 001111 lui → EXEC_I.
  - 000100 beq → BRANCH.
  - 000010 j → JUMP.
  - Any other op, or R-type with an unlisted funct: `illegal`=1, `instr_done`=1, next state FETCH. The instruction acts as a NOP because PC is already advanced.
- R-type funct to `ALUctr`: 100001→0000, 100000→0001, 100100→0010, 100101→0011, 100011→0100, 100010→0101, 101011→0110, 101010→0111.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `ext_op`=1. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `iord`=1. Next state is MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Next state is FETCH.
- MEM_WR: `mem_write`=1, `iord`=1, `instr_done`=1. Next state is FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `ALUctr` from funct. Next state is WB_R.
- WB_R: `reg_write`=1, `reg_dst`=1, `instr_done`=1. Next state is FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10. Next state is WB_I.
  - ori: `ALUctr`=0011, `ext_op`=0.
  - addiu: 0000, `ext_op`=1.
  - lui: 1000, `ext_op`=0.
- WB_I: `reg_write`=1, `reg_dst`=0, `instr_done`=1. Next state is FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `ALUctr`=0100, `pc_src`=01, `instr_done`=1. `pc_write`=`zero`; this is the only Mealy output. Next state is FETCH.
- JUMP: `pc_write`=1, `pc_src`=10, `instr_done`=1. Next state is FETCH.

## Timing
- Latency in cycles, FETCH included: lw 5; sw, R-type and I-type ALU 4; beq and j 3; illegal 2.
- Reset: when `rst_n`=0 at a rising edge, state becomes FETCH.
- While `rst_n`=0, every output is forced to 0 combinationally, including `ALUctr`=0000 and `state`=0.
- The first FETCH is the first cycle with `rst_n`=1.
- Reset asserted mid-instruction aborts it. There are no partial writes after the reset edge.
- `illegal` and `instr_done` are single-cycle pulses. They are never asserted in FETCH.
- `zero` is sampled only in BRANCH. It is ignored in every other state.

## Test plan
- Reset, then an R-type addu (op 000000, funct 100001) → `state` sequence 0,1,6,7,0. `ALUctr`=0000 in EXEC_R. `reg_write`=1 with `reg_dst`=1 in cycle 4.
- lw followed by sw → states 0,1,2,3,4 then 0,1,2,5. `mem_read`+`iord` in MEM_RD, `mem_write`+`iord` in MEM_WR. `instr_done` pulses at cycles 5 and 9.
- beq with `zero`=1, then beq with `zero`=0 → BRANCH has `pc_write`=1 and `pc_src`=01 for the first, `pc_write`=0 for the second. Each takes 3 cycles.
- ori, lui, addiu → `ALUctr`/`ext_op` in EXEC_I are 0011/0, 1000/0, 0000/1. WB_I has `reg_dst`=0.
- op 111111, and R-type with funct 000111 → `illegal`=1 in DECODE, then FETCH next cycle. No write enables are asserted.
- `rst_n` dropped during MEM_RD → next state is 0. All enables read 0 while `rst_n`=0. FETCH outputs reappear in the first cycle after release.
